// File: rtl/result_arb.sv
// result_arb: drains per-core result words onto one stream port as a counted batch.
// Ports: clk, rst (sync, active-high), start/batch_len (batch setup), req/data/grant (cores),
//   dst_ready/dst_valid/dst_data/dst_last (stream master), busy, done.
//   Macro RESULT_ARB_RR_EN selects round-robin arbitration (default: fixed priority, core 0 highest).
module result_arb #(
  parameter int NCORE = 16,
  parameter int DW    = 32,
  parameter int CW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CW-1:0]       batch_len,
  input  logic [NCORE-1:0]    req,
  input  logic [NCORE*DW-1:0] data,
  output logic [NCORE-1:0]    grant,
  input  logic                dst_ready,
  output logic                dst_valid,
  output logic [DW-1:0]       dst_data,
  output logic                dst_last,
  output logic                busy,
  output logic                done
);

  localparam int PW = (NCORE > 1) ? $clog2(NCORE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] remain;
  logic [PW-1:0] sel;
  logic          sel_any;
  logic [DW-1:0] sel_word;
  logic          load_ok;
  logic          take;

`ifdef RESULT_ARB_RR_EN
  logic [PW-1:0] ptr;

  // Search starts at the pointer and wraps; first requester found wins.
  always_comb begin
    logic [PW-1:0] j;
    j       = '0;
    sel     = '0;
    sel_any = 1'b0;
    for (int i = 0; i < NCORE; i++) begin
      j = PW'((int'(ptr) + i) % NCORE);
      if (!sel_any && req[j]) begin
        sel_any = 1'b1;
        sel     = j;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= (int'(sel) == NCORE - 1) ? '0 : sel + 1'b1;
    end
  end
`else
  always_comb begin
    sel     = '0;
    sel_any = 1'b0;
    for (int i = 0; i < NCORE; i++) begin
      if (!sel_any && req[i]) begin
        sel_any = 1'b1;
        sel     = PW'(i);
      end
    end
  end
`endif

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NCORE; k++) begin
      if (PW'(k) == sel) sel_word = data[k*DW +: DW];
    end
  end

  assign load_ok = !dst_valid || dst_ready;
  assign take    = (state == RUN) && load_ok && sel_any && (remain != '0);

  always_comb begin
    grant = '0;
    if (take) grant[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remain    <= '0;
      dst_valid <= 1'b0;
      dst_data  <= '0;
      dst_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Output slot: reload on grant, otherwise empty on acceptance.
      if (take) begin
        dst_valid <= 1'b1;
        dst_data  <= sel_word;
        dst_last  <= (remain == CW'(1));
      end else if (dst_valid && dst_ready) begin
        dst_valid <= 1'b0;
        dst_last  <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            if (batch_len != '0) begin
              remain <= batch_len;
              busy   <= 1'b1;
              state  <= RUN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (take) begin
            remain <= remain - 1'b1;
            if (remain == CW'(1)) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (dst_valid && dst_ready && dst_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/result_arb.md
# result_arb

Collects per-core result words from the NCORE processing cores and drains them, one word per transfer, onto the single outbound AXI-Stream-style master port. It sits between the core array and the DMA stream sink, replacing per-core completion gating with a counted batch: software programs a word count, pulses `start`, and the block arbitrates among requesting cores, asserts `dst_last` on the final word and pulses `done`.

## Interface
- `NCORE`, 16, number of requesting cores (2..32)
- `DW`, 32, result word width
- `CW`, 16, batch counter width
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; latches `batch_len`, begins a batch
- `batch_len`  in  CW  number of words in the batch (unsigned)
- `req`  in  NCORE  per-core result-valid; held high until granted
- `data`  in  NCORE*DW  core k word at bits [k*DW +: DW]
- `grant`  out  NCORE  one-hot, combinational; core k's word is taken this cycle
- `dst_ready`  in  1  sink ready
- `dst_valid`  out  1  output word valid
- `dst_data`  out  DW  output word
- `dst_last`  out  1  final word of batch, qualified by `dst_valid`
- `busy`  out  1  batch in progress
- `done`  out  1  one-cycle pulse after final word accepted

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: `start` with `batch_len` != 0 -> load `remain` = `batch_len`, go RUN. `start` with `batch_len` == 0 -> go DONE directly, no output words.
- RUN: output register `slot` (`dst_valid`, `dst_data`, `dst_last`) is loadable when `!dst_valid | dst_ready`. If loadable and any `req` set and `remain` != 0: arbiter selects one core, `grant` bit asserted, word copied into `slot`, `remain` decremented; if `remain` == 1 at grant, `dst_last` set with that word and FSM goes FLUSH.
- FLUSH: no grants; wait until `dst_valid & dst_ready` with `dst_last` = 1, then go DONE.
- DONE: `done` = 1 for exactly one cycle, `busy` drops, return IDLE.
- `busy` = 1 in RUN and FLUSH.
- `start` outside IDLE is ignored; `batch_len` sampled only on accepted `start`.
- `slot` clears `dst_valid`/`dst_last` when accepted and not reloaded the same cycle.
- `grant` is 0 whenever the slot is not loadable, state is not RUN, or `req` == 0.
- Arbitration: see Configuration. Ties never produce more than one grant bit.
- `req` bits for cores not granted are left pending; block never drops a request.

## Timing
- Reset values: `dst_valid` 0, `dst_last` 0, `dst_data` 0, `busy` 0, `done` 0, `grant` 0, RR pointer 0, FSM IDLE.
- `rst` mid-batch: all state returns to reset values next edge; partial batch discarded, no `done`.
- `start` at edge n -> `busy` = 1 from n+1; earliest `grant` in cycle n+1.
- Grant in cycle n -> `dst_valid` = 1 from n+1 (1-cycle latency).
- With `dst_ready` held high and `req` continuously available: one word per cycle, no bubbles.
- `dst_ready` low with `dst_valid` high: `dst_data`/`dst_last` held stable, no grant.
- Final word accepted at edge m -> `done` = 1 in cycle m+1, `busy` = 0 in cycle m+1.
- Core must deassert/advance its `req` the cycle after its `grant`.

## Configuration
- `RESULT_ARB_RR_EN` defined: round-robin; after granting core k, priority starts at (k+1) mod NCORE; pointer updates only on a grant.
- Not defined: fixed priority, lowest index `req` wins; pointer logic absent.

## Test plan
- `batch_len`=4, `req`=16'h0001 with data 0x10..0x13 in turn, `dst_ready`=1 -> 4 beats 0x10..0x13 on consecutive cycles, `dst_last` only on 0x13, `done` one cycle after.
- RR build, `req`=16'hFFFF held, `batch_len`=18 -> grant order cores 0..15,0,1; `dst_last` on the core-1 word; fixed-priority build -> all 18 grants to core 0.
- `batch_len`=3, `dst_ready` toggling 1,0,0,1,... -> each word held stable while `dst_ready`=0, exactly 3 beats, no duplicate or lost word.
- `start` with `batch_len`=0 -> `done` pulse next cycle, `dst_valid` never asserted, `grant` stays 0.
- `batch_len`=8, `rst` pulsed after 3 beats -> all outputs 0 next cycle, no `done`; new `start` with `batch_len`=2 completes normally.
- `start` pulsed again while `busy` -> ignored, original count of words and single `done` preserved.
